// File: rtl/bsg_serial_in_parallel_out_passthrough_dynamic.sv
`default_nettype none
// ============================================================================
// Module      : bsg_serial_in_parallel_out_passthrough_dynamic
// Description : Dynamic-length deserializer. Gathers len_i+1 serial words into
//               one parallel beat. Words 0..len-1 are held in registers and the
//               final word passes straight through, so the beat is offered in
//               the same cycle its last word arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_serial_in_parallel_out_passthrough_dynamic #(
    parameter int width_p       = 8,
    parameter int els_p         = 4,
    parameter int hi_to_lo_p    = 0,
    parameter int lg_max_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    input  logic [lg_max_els_lp-1:0]   len_i,
    output logic                       ready_and_o,
    output logic                       v_o,
    output logic [els_p*width_p-1:0]   data_o,
    output logic [lg_max_els_lp-1:0]   len_o,
    input  logic                       ready_and_i
);

    // Beat words in serial order (word k in w_word[k]), before any reversal.
    logic [width_p-1:0] w_word [els_p];

    generate
        if (els_p == 1) begin : g_single
            // A one-word beat is pure passthrough: there is nothing to collect.
            assign v_o         = v_i;
            assign ready_and_o = ready_and_i;
            assign w_word[0]   = data_i;
            assign len_o       = '0;
        end else begin : g_multi
            logic [lg_max_els_lp-1:0] r_count;
            logic [lg_max_els_lp-1:0] r_len;
            logic [width_p-1:0]       r_slot [els_p-1];

            logic [lg_max_els_lp-1:0] w_eff_len;
            logic                     w_last;
            logic                     w_accept;

            // Length is only taken from len_i on word 0; later words use the latched copy.
            assign w_eff_len   = (r_count == '0) ? len_i : r_len;
            assign w_last      = (r_count == w_eff_len);
            assign v_o         = v_i & w_last;
            // Non-last words never wait; the last word waits for the beat to be taken.
            assign ready_and_o = ~w_last | ready_and_i;
            assign w_accept    = v_i & ready_and_o;
            assign len_o       = w_eff_len;

            // Track position in the beat, latch the length and store non-last words.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_count <= '0;
                    r_len   <= '0;
                    for (int i = 0; i < els_p - 1; i++) begin
                        r_slot[i] <= '0;
                    end
                end else if (w_accept) begin
                    if (w_last) begin
                        // Slots are left as-is; r_count gates them out of data_o.
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + lg_max_els_lp'(1);
                        if (r_count == '0) begin
                            r_len <= len_i;
                        end
                        for (int i = 0; i < els_p - 1; i++) begin
                            if (r_count == lg_max_els_lp'(i)) begin
                                r_slot[i] <= data_i;
                            end
                        end
                    end
                end
            end

            // Stored words below the current position, live word at it, zero above.
            for (genvar j = 0; j < els_p; j++) begin : g_word
                localparam logic [lg_max_els_lp-1:0] c_j = lg_max_els_lp'(j);
                if (j < els_p - 1) begin : g_reg
                    assign w_word[j] = (c_j < r_count)  ? r_slot[j] :
                                       (c_j == r_count) ? data_i    : '0;
                end else begin : g_top
                    // Highest slot is only ever filled by the passthrough word.
                    assign w_word[j] = (c_j == r_count) ? data_i : '0;
                end
            end

`ifndef SYNTHESIS
            // Catch illegal lengths and undriven handshakes once out of reset.
            always @(posedge clk_i) begin
                if (reset_n_i) begin
                    assert (!$isunknown(v_i) && !$isunknown(ready_and_i))
                        else $error("X on v_i or ready_and_i");
                    if (v_i && (r_count == '0)) begin
                        assert (int'(len_i) < els_p)
                            else $error("len_i out of range on word 0");
                    end
                end
            end
`endif
        end
    endgenerate

    // Place each word into the output vector, reversed when hi_to_lo_p is set.
    generate
        for (genvar j = 0; j < els_p; j++) begin : g_pack
            localparam int c_pos = (hi_to_lo_p != 0) ? (els_p - 1 - j) : j;
            assign data_o[c_pos*width_p +: width_p] = w_word[j];
        end
    endgenerate

endmodule
`default_nettype wire
